// File: rtl/down_timer_arbiter_if.sv
// Handshake bundle between the two timer requesters and the shared down-counter arbiter.
`timescale 1ns/1ps
interface down_timer_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] load0;
  logic [WIDTH-1:0] load1;
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] count;

  modport master (
    output req, load0, load1,
    input  gnt, busy, done, count
  );

  modport slave (
    input  req, load0, load1,
    output gnt, busy, done, count
  );
endinterface

// File: rtl/down_timer_arbiter.sv
// Round-robin share of one down counter between two requesters; grant 1 cycle after req,
// done L+2 cycles after req; no backpressure, a requester cancels by dropping req mid-count.
`timescale 1ns/1ps
module down_timer_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  down_timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   last_srv;
  logic   win;
  logic   cur;

  // Winner on contention is whoever was not served last.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b11) begin
      win = ~last_srv;
    end else begin
      win = bus.req[1];
    end
  end

  assign cur = bus.gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.gnt   <= 2'b00;
      bus.done  <= 2'b00;
      bus.busy  <= 1'b0;
      bus.count <= '0;
      last_srv  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 2'b00;
          if (bus.req != 2'b00) begin
            state     <= COUNT;
            bus.gnt   <= win ? 2'b10 : 2'b01;
            bus.busy  <= 1'b1;
            bus.count <= win ? bus.load1 : bus.load0;
          end
        end

        COUNT: begin
          // A cancel beats reaching zero: no done is owed to a requester that left.
          if (!bus.req[cur]) begin
            state     <= IDLE;
            bus.gnt   <= 2'b00;
            bus.busy  <= 1'b0;
            bus.count <= '0;
            last_srv  <= cur;
          end else if (bus.count == '0) begin
            state    <= DONE;
            bus.done <= bus.gnt;
          end else begin
            bus.count <= bus.count - ONE;
          end
        end

        DONE: begin
          state     <= IDLE;
          bus.gnt   <= 2'b00;
          bus.done  <= 2'b00;
          bus.busy  <= 1'b0;
          bus.count <= '0;
          last_srv  <= cur;
        end

        default: begin
          state     <= IDLE;
          bus.gnt   <= 2'b00;
          bus.done  <= 2'b00;
          bus.busy  <= 1'b0;
          bus.count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/down_timer_arbiter.md
Name: down_timer_arbiter

Overview:
- Shares one WIDTH-bit synchronous down counter between two requesters, each of which needs a countdown timer.
- Grants the counter round-robin and loads the winner's start value.
- Decrements once per cycle to zero, then pulses a per-requester done.
- Sits between the counter datapath and the control logic that needs timed delays.

Parameters:
WIDTH, 4, width of the load values and of the counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous reset, active-high
req  input  2  per-requester request; held high until that requester's done, or dropped to cancel
load0  input  WIDTH  start value for requester 0; sampled only in the grant cycle
load1  input  WIDTH  start value for requester 1; sampled only in the grant cycle
gnt  output  2  one-hot grant; high from the first COUNT cycle through the DONE cycle
busy  output  1  high whenever state is not IDLE
done  output  2  one-cycle pulse to the granted requester when its countdown reaches zero
count  output  WIDTH  current counter value; 0 in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a clk edge, every register takes its reset value on that edge.
- Reset values:
  - state = IDLE
  - gnt = 00, done = 00, busy = 0, count = 0
  - last-served pointer = 1, so requester 0 wins the first contention.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - req = 00: stay in IDLE.
  - Exactly one req bit high: grant it.
  - Both high: grant the requester that is not the last-served one.
  - On the grant edge: state goes to COUNT, gnt becomes one-hot for the winner, count is loaded with the winner's load value.
- COUNT:
  - count != 0: count decrements by 1 each cycle; stay in COUNT.
  - count == 0: next state is DONE; count holds at 0.
  - The granted req bit low in any COUNT cycle cancels the countdown. Next state is IDLE, gnt = 00, count = 0, no done pulse. Last-served is updated to the cancelled requester.
  - The other requester's req is ignored until the state returns to IDLE.
- DONE:
  - Lasts exactly one cycle with done[i] = 1 and gnt[i] = 1.
  - Then IDLE, gnt = 00, count = 0, last-served = i.
  - req is not checked in DONE; done is always delivered once the count reaches zero.
- Latency:
  - req rises in cycle T while IDLE, with load value L.
  - Grant and count = L appear in T+1.
  - done pulses in cycle T+L+2.
  - IDLE is reached at T+L+3.
  - L = 0: done at T+2.
- Re-arbitration:
  - At least one IDLE cycle separates consecutive grants; IDLE is never skipped.
  - A requester that keeps req high after its done is treated as a new request and competes round-robin.
  - With both requesting continuously, grants alternate 0,1,0,1...
- Arithmetic: count is unsigned WIDTH bits and never wraps. A decrement from 0 cannot occur because zero exits COUNT.
- Reset mid-operation: rst has priority over every transition. Any state returns to IDLE with the reset values above on the next edge, and no done pulse is produced.
- Invariants:
  - gnt and done are each zero-or-one-hot.
  - done implies the matching gnt.
  - busy = (gnt != 00).
  - count = 0 whenever gnt = 00.

Test Plan:
- Single request: rst high 2 cycles then low; req = 01, load0 = 3 -> gnt = 01 next cycle; count goes 3,2,1,0; done = 01 for one cycle; then gnt = 00, busy = 0.
- Zero load: req = 10, load1 = 0 -> one COUNT cycle with count = 0, then done = 10; done comes 2 cycles after req.
- Contention and fairness: req = 11 held after reset, load0 = 2, load1 = 5 -> requester 0 served first, done = 01; one IDLE cycle; requester 1 served, count starts at 5, done = 10; then requester 0 again.
- Cancel: req = 01, load0 = 9; drop req[0] when count = 6 -> next cycle IDLE, count = 0, no done. A pending req[1] is granted on the following edge.
- Reset mid-count: requester 1 granted with count = 4; rst pulsed high for one cycle -> next cycle gnt = 00, count = 0, busy = 0, no done. After reset, req = 11 grants requester 0 first.
- Max value: load0 = 15 -> count goes 15 down to 0 with no wrap; done arrives 17 cycles after req.
